voice_alloc_sched: RTL and testbench
====================================

Name: voice_alloc_sched

Overview:
- Synchronous voice allocator and scheduler between the MIDI byte parser and the synth engine's voice array.
- Accepts note-on/note-off requests over a valid/ready handshake.
- Picks a voice: free first, then the oldest releasing voice, then steals the oldest held voice.
- Emits ordered on/off events and per-voice gate bits consumed by the envelope generators.

Parameters:
- VOICES, 8, number of voices (power of two).
- V_WIDTH, 3, log2(VOICES).

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset_reg  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_on  in  1  1 = note-on, 0 = note-off.
- req_note  in  8  MIDI key number.
- req_vel  in  8  velocity. A note-on with velocity 0 is treated as a note-off.
- all_off  in  1  all-notes-off pulse (CC 0x7B).
- voice_free  in  VOICES  engine flag: envelope of voice v has finished.
- keys_on  out  VOICES  gate per voice.
- evt_valid  out  1  one-cycle event strobe.
- evt_on  out  1  1 = gate-on event, 0 = gate-off event.
- evt_voice  out  V_WIDTH  voice index of the event.
- evt_note  out  8  key of the event (8'hFF on off events).
- evt_vel  out  8  velocity of the event.
- active_keys  out  V_WIDTH+1  count of set keys_on bits.
- steal  out  1  one-cycle pulse when a held voice is stolen.

Behaviour:
- Reset (async, reset_reg=1):
  - keys_on=0, evt_valid=0, evt_on=0, evt_voice=0, evt_note=8'hFF, evt_vel=0, active_keys=0, steal=0.
  - FSM in IDLE. All note[v]=8'hFF. age[v]=v.
  - Reset mid-operation drops any in-flight request with no event.
- Per-voice state: note[v] (8b), age[v] (V_WIDTH b). Ages always form a permutation of 0..VOICES-1; 0 = newest.
- FSM states: IDLE, SCAN, MATCH, KILL, GRANT.
  - req_ready=1 only in IDLE with all_off=0.
  - Accept = req_valid & req_ready.
- IDLE: on accept, latch note/vel/type.
  - Note-on with vel≠0 -> SCAN.
  - Otherwise -> MATCH.
- SCAN (1 cycle): choose a target by priority.
  - (a) Lowest-index v with keys_on[v]=0 and voice_free[v]=1.
  - (b) Else the v with keys_on[v]=0 and maximum age.
  - (c) Else the v with maximum age (steal).
  - (a)/(b) -> GRANT. (c) -> KILL.
- KILL (1 cycle): evt_valid=1, evt_on=0, evt_voice=victim, evt_note=8'hFF, evt_vel=0, steal=1; clear keys_on[victim]; -> GRANT.
- GRANT (1 cycle):
  - evt_valid=1, evt_on=1, evt_voice=target, evt_note/evt_vel=latched values.
  - Set keys_on[target], note[target]=key.
  - Ages: each voice with age < old age[target] increments; age[target]=0.
  - -> IDLE.
- MATCH (1 cycle):
  - Find the lowest-index v with keys_on[v]=1 and note[v]==key.
  - If found: off event as in KILL (steal=0), clear gate, note[v]=8'hFF.
  - If not found: no event.
  - -> IDLE.
- Latency from accept edge to evt_valid:
  - Non-steal note-on: 2 cycles.
  - Steal: off event at 2 cycles, on event at 3 cycles.
  - Note-off: 1 cycle.
- Throughput: one request per 3 (or 4 on steal) cycles; req_ready low otherwise.
- active_keys: registered popcount of keys_on, updated the cycle after any gate change.
- all_off: sampled in every state, overrides everything.
  - Next cycle: keys_on=0, all note=8'hFF, active_keys=0, FSM->IDLE.
  - In-flight request dropped; no events emitted; ages unchanged.
- Duplicate note-on of an already-held key allocates a second voice; a later note-off releases the lowest-index match only.
- voice_free is read only in SCAN; a voice whose gate is set is never chosen under (a).

Optional Feature:
- RETRIGGER_SAME_NOTE_EN.
- Defined: SCAN first checks for a voice with keys_on=1 and note==key (lowest index).
  - If found, go to GRANT on that voice with no KILL and steal=0.
  - Gate stays set; an on event is emitted and its age is refreshed to 0.
- Undefined: behaviour as above (duplicate allocation).

Test Plan:
- Reset, then note-on 60/100 -> evt on, voice 0, note 60, vel 100, 2 cycles after accept; keys_on=8'h01; active_keys=1.
- 8 note-ons 60..67, all voice_free=1, then note-on 70 -> KILL voice 0 (oldest) with steal=1, then on event voice 0 note 70; active_keys=8.
- Note-off 62 -> off event voice 2 one cycle after accept; note-on 72 with voice_free[2]=0 and all other gates set -> voice 2 reused via rule (b).
- Note-on 64 with vel 0 -> handled as note-off; note-off for a key not held -> no evt_valid; FSM back in IDLE (req_ready=1 on the 2nd cycle).
- all_off asserted during SCAN of a pending note-on -> no events; keys_on=0, active_keys=0 next cycle; req_ready low while all_off=1.
- Assert reset_reg mid-GRANT -> all outputs at reset values immediately, asynchronous to the clock; no event emitted.

Source files
------------

// File: rtl/voice_alloc_sched.sv
// voice_alloc_sched
//   Voice allocator / scheduler sitting between the MIDI byte parser and the
//   synth engine voice array. Note requests arrive on a valid/ready handshake.
//   A voice is chosen in this order: a free voice, then the oldest releasing
//   voice, then the oldest held voice (steal). Ordered on/off events and the
//   per-voice gate bits are produced for the envelope generators.
//
//   Optional build macro: RETRIGGER_SAME_NOTE_EN
//     When defined, a note-on for a key already gated on re-triggers that
//     voice (on event, age refreshed) instead of allocating a second voice.
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   reset_reg    in   asynchronous active-high reset
//   req_valid    in   request present
//   req_ready    out  request accepted this cycle when high
//   req_on       in   1 = note-on, 0 = note-off
//   req_note     in   MIDI key
//   req_vel      in   velocity (note-on with 0 velocity acts as note-off)
//   all_off      in   all-notes-off pulse
//   voice_free   in   per-voice envelope-finished flag
//   keys_on      out  per-voice gate
//   evt_valid    out  one-cycle event strobe
//   evt_on       out  1 = gate-on event, 0 = gate-off event
//   evt_voice    out  voice index of the event
//   evt_note     out  key of the event (8'hFF on off events)
//   evt_vel      out  velocity of the event
//   active_keys  out  registered popcount of keys_on
//   steal        out  one-cycle pulse when a held voice is stolen
module voice_alloc_sched #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset_reg,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_on,
  input  logic [7:0]         req_note,
  input  logic [7:0]         req_vel,
  input  logic               all_off,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               evt_valid,
  output logic               evt_on,
  output logic [V_WIDTH-1:0] evt_voice,
  output logic [7:0]         evt_note,
  output logic [7:0]         evt_vel,
  output logic [V_WIDTH:0]   active_keys,
  output logic               steal
);

  localparam int unsigned NV = VOICES;

  typedef enum logic [2:0] {IDLE, SCAN, MATCH, KILL, GRANT} state_t;

  state_t             state_q;
  logic [VOICES-1:0]  keys_on_q;
  logic [7:0]         note_q [VOICES];
  logic [V_WIDTH-1:0] age_q  [VOICES];
  logic [7:0]         key_q;
  logic [7:0]         vel_q;
  logic [V_WIDTH-1:0] tgt_q;
  logic               evt_valid_q;
  logic               evt_on_q;
  logic [V_WIDTH-1:0] evt_voice_q;
  logic [7:0]         evt_note_q;
  logic [7:0]         evt_vel_q;
  logic [V_WIDTH:0]   active_keys_q;
  logic               steal_q;

  // Search results over the voice array
  logic               free_hit, rel_hit, match_hit;
  logic [V_WIDTH-1:0] free_idx, rel_idx, old_idx, match_idx;
  logic [V_WIDTH-1:0] rel_age, tgt_age;
  logic [V_WIDTH:0]   popcnt_d;

  always_comb begin
    free_hit  = 1'b0;
    free_idx  = '0;
    rel_hit   = 1'b0;
    rel_idx   = '0;
    rel_age   = '0;
    old_idx   = '0;
    match_hit = 1'b0;
    match_idx = '0;
    popcnt_d  = '0;
    for (int unsigned v = 0; v < NV; v++) begin
      if (!free_hit && !keys_on_q[v] && voice_free[v]) begin
        free_hit = 1'b1;
        free_idx = V_WIDTH'(v);
      end
      if (!keys_on_q[v] && (!rel_hit || age_q[v] > rel_age)) begin
        rel_hit = 1'b1;
        rel_idx = V_WIDTH'(v);
        rel_age = age_q[v];
      end
      // Ages are a permutation, so exactly one voice holds the maximum.
      if (age_q[v] == V_WIDTH'(NV - 1)) old_idx = V_WIDTH'(v);
      if (!match_hit && keys_on_q[v] && note_q[v] == key_q) begin
        match_hit = 1'b1;
        match_idx = V_WIDTH'(v);
      end
      popcnt_d = popcnt_d + {{V_WIDTH{1'b0}}, keys_on_q[v]};
    end
    tgt_age = age_q[tgt_q];
  end

  always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
    if (reset_reg) begin
      state_q       <= IDLE;
      keys_on_q     <= '0;
      key_q         <= '0;
      vel_q         <= '0;
      tgt_q         <= '0;
      evt_valid_q   <= 1'b0;
      evt_on_q      <= 1'b0;
      evt_voice_q   <= '0;
      evt_note_q    <= 8'hFF;
      evt_vel_q     <= '0;
      active_keys_q <= '0;
      steal_q       <= 1'b0;
      for (int unsigned v = 0; v < NV; v++) begin
        note_q[v] <= 8'hFF;
        age_q[v]  <= V_WIDTH'(v);
      end
    end else begin
      evt_valid_q   <= 1'b0;
      steal_q       <= 1'b0;
      active_keys_q <= popcnt_d;
      if (all_off) begin
        // Drops any in-flight request; ages are deliberately left alone.
        state_q       <= IDLE;
        keys_on_q     <= '0;
        active_keys_q <= '0;
        for (int unsigned v = 0; v < NV; v++) note_q[v] <= 8'hFF;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_valid) begin
              key_q   <= req_note;
              vel_q   <= req_vel;
              state_q <= (req_on && req_vel != 8'd0) ? SCAN : MATCH;
            end
          end
          SCAN: begin
`ifdef RETRIGGER_SAME_NOTE_EN
            if (match_hit) begin
              tgt_q   <= match_idx;
              state_q <= GRANT;
            end else
`endif
            if (free_hit) begin
              tgt_q   <= free_idx;
              state_q <= GRANT;
            end else if (rel_hit) begin
              tgt_q   <= rel_idx;
              state_q <= GRANT;
            end else begin
              tgt_q   <= old_idx;
              state_q <= KILL;
            end
          end
          KILL: begin
            evt_valid_q      <= 1'b1;
            evt_on_q         <= 1'b0;
            evt_voice_q      <= tgt_q;
            evt_note_q       <= 8'hFF;
            evt_vel_q        <= '0;
            steal_q          <= 1'b1;
            keys_on_q[tgt_q] <= 1'b0;
            state_q          <= GRANT;
          end
          GRANT: begin
            evt_valid_q      <= 1'b1;
            evt_on_q         <= 1'b1;
            evt_voice_q      <= tgt_q;
            evt_note_q       <= key_q;
            evt_vel_q        <= vel_q;
            keys_on_q[tgt_q] <= 1'b1;
            note_q[tgt_q]    <= key_q;
            for (int unsigned v = 0; v < NV; v++) begin
              if (V_WIDTH'(v) == tgt_q)  age_q[v] <= '0;
              else if (age_q[v] < tgt_age) age_q[v] <= age_q[v] + 1'b1;
            end
            state_q <= IDLE;
          end
          MATCH: begin
            if (match_hit) begin
              evt_valid_q          <= 1'b1;
              evt_on_q             <= 1'b0;
              evt_voice_q          <= match_idx;
              evt_note_q           <= 8'hFF;
              evt_vel_q            <= '0;
              keys_on_q[match_idx] <= 1'b0;
              note_q[match_idx]    <= 8'hFF;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign req_ready   = (state_q == IDLE) && !all_off;
  assign keys_on     = keys_on_q;
  assign evt_valid   = evt_valid_q;
  assign evt_on      = evt_on_q;
  assign evt_voice   = evt_voice_q;
  assign evt_note    = evt_note_q;
  assign evt_vel     = evt_vel_q;
  assign active_keys = active_keys_q;
  assign steal       = steal_q;

endmodule

// File: tb/tb_voice_alloc_sched.sv
// Testbench for voice_alloc_sched (default build, duplicate-allocation mode).
module tb_voice_alloc_sched;

  localparam int K_ON    = 0;  // on event 2 cycles after accept
  localparam int K_STEAL = 1;  // steal off at 2, on at 3
  localparam int K_OFF   = 2;  // off event 1 cycle after accept
  localparam int K_NONE  = 3;  // no event

  typedef struct {
    logic       on;
    logic [7:0] note;
    logic [7:0] vel;
    logic [7:0] free;
    int         kind;
    logic [2:0] voice;
    logic [7:0] keys;
    logic [3:0] active;
  } vec_t;

  logic       CLOCK_50 = 1'b0;
  logic       reset_reg;
  logic       req_valid;
  logic       req_ready;
  logic       req_on;
  logic [7:0] req_note;
  logic [7:0] req_vel;
  logic       all_off;
  logic [7:0] voice_free;
  logic [7:0] keys_on;
  logic       evt_valid;
  logic       evt_on;
  logic [2:0] evt_voice;
  logic [7:0] evt_note;
  logic [7:0] evt_vel;
  logic [3:0] active_keys;
  logic       steal;

  int tests    = 0;
  int failures = 0;

  voice_alloc_sched #(.VOICES(8), .V_WIDTH(3)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_reg  (reset_reg),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_on     (req_on),
    .req_note   (req_note),
    .req_vel    (req_vel),
    .all_off    (all_off),
    .voice_free (voice_free),
    .keys_on    (keys_on),
    .evt_valid  (evt_valid),
    .evt_on     (evt_on),
    .evt_voice  (evt_voice),
    .evt_note   (evt_note),
    .evt_vel    (evt_vel),
    .active_keys(active_keys),
    .steal      (steal)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " keys_on"},     32'(keys_on),     32'h00);
    chk({nm, " evt_valid"},   32'(evt_valid),   32'h0);
    chk({nm, " evt_on"},      32'(evt_on),      32'h0);
    chk({nm, " evt_voice"},   32'(evt_voice),   32'h0);
    chk({nm, " evt_note"},    32'(evt_note),    32'hFF);
    chk({nm, " evt_vel"},     32'(evt_vel),     32'h0);
    chk({nm, " active_keys"}, 32'(active_keys), 32'h0);
    chk({nm, " steal"},       32'(steal),       32'h0);
  endtask

  // Called at a negedge. Issues one request and checks every cycle up to
  // four cycles after the accept edge, then the gates and key count.
  task automatic run_vec(input vec_t v, input string nm);
    int  w;
    bit  exp_v, exp_on, exp_st;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge CLOCK_50);
      w++;
    end
    chk({nm, " ready"}, 32'(req_ready), 32'h1);
    req_valid  = 1'b1;
    req_on     = v.on;
    req_note   = v.note;
    req_vel    = v.vel;
    voice_free = v.free;
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    chk({nm, " ready k0"}, 32'(req_ready), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLOCK_50);
      exp_v  = (v.kind == K_ON && k == 2) || (v.kind == K_STEAL && (k == 2 || k == 3)) ||
               (v.kind == K_OFF && k == 1);
      exp_on = (v.kind == K_ON) || (v.kind == K_STEAL && k == 3);
      exp_st = (v.kind == K_STEAL && k == 2);
      chk($sformatf("%s evt_valid k%0d", nm, k), 32'(evt_valid), 32'(exp_v));
      chk($sformatf("%s steal k%0d", nm, k), 32'(steal), 32'(exp_st));
      if (k == 1)
        chk({nm, " ready k1"}, 32'(req_ready), 32'(v.kind == K_OFF || v.kind == K_NONE));
      if (exp_v) begin
        chk($sformatf("%s evt_on k%0d", nm, k),    32'(evt_on),    32'(exp_on));
        chk($sformatf("%s evt_voice k%0d", nm, k), 32'(evt_voice), 32'(v.voice));
        chk($sformatf("%s evt_note k%0d", nm, k),  32'(evt_note),  exp_on ? 32'(v.note) : 32'hFF);
        chk($sformatf("%s evt_vel k%0d", nm, k),   32'(evt_vel),   exp_on ? 32'(v.vel) : 32'h0);
      end
    end
    chk({nm, " keys_on"},     32'(keys_on),     32'(v.keys));
    chk({nm, " active_keys"}, 32'(active_keys), 32'(v.active));
  endtask

  vec_t tbl [19];
  vec_t hv;

  initial begin
    // Expected voices follow from reset ages age[v]=v and the aging rule.
    tbl[0]  = '{1'b1, 8'd60, 8'd100, 8'hFF, K_ON,    3'd0, 8'h01, 4'd1};
    tbl[1]  = '{1'b1, 8'd61, 8'd101, 8'hFF, K_ON,    3'd1, 8'h03, 4'd2};
    tbl[2]  = '{1'b1, 8'd62, 8'd102, 8'hFF, K_ON,    3'd2, 8'h07, 4'd3};
    tbl[3]  = '{1'b1, 8'd63, 8'd103, 8'hFF, K_ON,    3'd3, 8'h0F, 4'd4};
    tbl[4]  = '{1'b1, 8'd64, 8'd104, 8'hFF, K_ON,    3'd4, 8'h1F, 4'd5};
    tbl[5]  = '{1'b1, 8'd65, 8'd105, 8'hFF, K_ON,    3'd5, 8'h3F, 4'd6};
    tbl[6]  = '{1'b1, 8'd66, 8'd106, 8'hFF, K_ON,    3'd6, 8'h7F, 4'd7};
    tbl[7]  = '{1'b1, 8'd67, 8'd107, 8'hFF, K_ON,    3'd7, 8'hFF, 4'd8};
    tbl[8]  = '{1'b1, 8'd70, 8'd90,  8'hFF, K_STEAL, 3'd0, 8'hFF, 4'd8};
    tbl[9]  = '{1'b0, 8'd62, 8'd0,   8'hFF, K_OFF,   3'd2, 8'hFB, 4'd7};
    tbl[10] = '{1'b1, 8'd72, 8'd80,  8'hFB, K_ON,    3'd2, 8'hFF, 4'd8};
    tbl[11] = '{1'b1, 8'd64, 8'd0,   8'hFF, K_OFF,   3'd4, 8'hEF, 4'd7};
    tbl[12] = '{1'b0, 8'd99, 8'd0,   8'hFF, K_NONE,  3'd0, 8'hEF, 4'd7};
    tbl[13] = '{1'b1, 8'd61, 8'd50,  8'hFF, K_ON,    3'd4, 8'hFF, 4'd8};
    tbl[14] = '{1'b0, 8'd61, 8'd0,   8'hFF, K_OFF,   3'd1, 8'hFD, 4'd7};
    tbl[15] = '{1'b0, 8'd61, 8'd0,   8'hFF, K_OFF,   3'd4, 8'hED, 4'd6};
    tbl[16] = '{1'b1, 8'd80, 8'd10,  8'h00, K_ON,    3'd1, 8'hEF, 4'd7};
    tbl[17] = '{1'b1, 8'd81, 8'd11,  8'hFF, K_ON,    3'd4, 8'hFF, 4'd8};
    tbl[18] = '{1'b1, 8'd82, 8'd12,  8'hFF, K_STEAL, 3'd3, 8'hFF, 4'd8};

    reset_reg  = 1'b1;
    req_valid  = 1'b0;
    req_on     = 1'b0;
    req_note   = 8'd0;
    req_vel    = 8'd0;
    all_off    = 1'b0;
    voice_free = 8'hFF;
    #12;
    check_reset_outputs("reset");
    @(negedge CLOCK_50);
    reset_reg = 1'b0;
    @(negedge CLOCK_50);

    for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // all_off while a note-on sits in SCAN
    req_valid = 1'b1; req_on = 1'b1; req_note = 8'd90; req_vel = 8'd5; voice_free = 8'hFF;
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    all_off   = 1'b1;
    @(negedge CLOCK_50);
    chk("alloff keys_on",   32'(keys_on),     32'h00);
    chk("alloff active",    32'(active_keys), 32'h0);
    chk("alloff evt_valid", 32'(evt_valid),   32'h0);
    chk("alloff ready",     32'(req_ready),   32'h0);
    all_off = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge CLOCK_50);
      chk($sformatf("alloff evt_valid k%0d", k), 32'(evt_valid), 32'h0);
      chk($sformatf("alloff keys k%0d", k),      32'(keys_on),   32'h00);
    end
    chk("alloff ready after", 32'(req_ready), 32'h1);
    // Notes were cleared; ages kept, so rule (b) picks voice 5 (age 7).
    hv = '{1'b0, 8'd82, 8'd0, 8'hFF, K_NONE, 3'd0, 8'h00, 4'd0};
    run_vec(hv, "post_alloff off");
    hv = '{1'b1, 8'd60, 8'd100, 8'h00, K_ON, 3'd5, 8'h20, 4'd1};
    run_vec(hv, "post_alloff age");

    // Asynchronous reset while in GRANT
    req_valid = 1'b1; req_on = 1'b1; req_note = 8'd61; req_vel = 8'd70; voice_free = 8'hFF;
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    @(negedge CLOCK_50);
    #2 reset_reg = 1'b1;
    #1 check_reset_outputs("async reset");
    @(negedge CLOCK_50);
    chk("reset held evt_valid", 32'(evt_valid), 32'h0);
    chk("reset held keys_on",   32'(keys_on),   32'h00);
    reset_reg = 1'b0;
    @(negedge CLOCK_50);
    // Reset ages make voice 7 the oldest releasing voice.
    hv = '{1'b1, 8'd60, 8'd100, 8'h00, K_ON, 3'd7, 8'h80, 4'd1};
    run_vec(hv, "post_reset age");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
